keypad_scan: RTL and testbench
==============================

Name: keypad_scan

Overview:
- Input-side counterpart of the multiplexed display scanner: drives a 4x4 matrix keypad one column at a time and reads back the rows.
- Debounces press and release, encodes the pressed key as a 4-bit code and offers it to downstream logic through a valid/ack holding register.
- Sits between the board keypad pins and the user logic, for example a code register feeding the display ROM.

Parameters:
- CLK_DIV, 50000, system clocks per scan tick (2..2^20); all scanning and debouncing advance only on ticks.
- DEBOUNCE_TICKS, 4, consecutive identical tick samples required to accept a press or a release (1..255).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ROW  input  4  keypad rows, active-low, pulled up externally; asynchronous to clk.
- COL  output  4  keypad column drive, active-low one-hot; bit i low selects column i.
- key_code  output  4  {row_idx[1:0], col_idx[1:0]} of the last accepted key.
- key_valid  output  1  high while key_code holds an unacknowledged key.
- key_ack  input  1  consumer accepts key_code; meaningful only while key_valid=1.
- overrun  output  1  sticky: a key was accepted while key_valid was still pending.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. While rst_n=0:
  - COL=4'b1110, key_code=0, key_valid=0, overrun=0.
  - State=SCAN, column index=0, tick and debounce counters=0, synchronizer flops=4'b1111.
  - Reset mid-press discards all progress; scanning restarts at column 0.
- Tick: free-running counter 0..CLK_DIV-1. tick=1 for one cycle when the count equals CLK_DIV-1, then the count wraps to 0.
- Row sampling: ROW passes through a 2-flop synchronizer (rs). Decisions use rs only on tick cycles, so a column is driven for a full tick period before it is evaluated.
- Row index: lowest-numbered 0 bit of rs; multiple rows low resolve to the lowest index.
- FSM states and transitions (all evaluated on tick only):
  - SCAN:
    - rs==4'b1111: advance column 0->1->2->3->0; COL updates on the same edge.
    - Otherwise: latch rs as ref_row, column frozen, cnt=0, go to DEBOUNCE.
  - DEBOUNCE:
    - rs==ref_row: cnt+1. When cnt reaches DEBOUNCE_TICKS, accept the key (see Accept) and go to HOLD.
    - rs!=ref_row: go to SCAN with the same column; no output change.
  - HOLD:
    - Column stays frozen.
    - rs==4'b1111: cnt=0, go to RELEASE.
    - Any other value (including a different row): stay in HOLD; no repeat and no new key.
  - RELEASE:
    - rs==4'b1111: cnt+1. When cnt reaches DEBOUNCE_TICKS, advance column and go to SCAN.
    - Any 0 bit: go to HOLD; treated as bounce, not a new key.
- Accept (registered on the accepting tick edge):
  - key_valid=0, or key_ack=1 in the same cycle: load key_code, key_valid=1; overrun unchanged.
  - key_valid=1 and key_ack=0: key_code keeps its old value, key_valid stays 1, overrun=1.
- Handshake:
  - key_ack=1 while key_valid=1 with no accept that cycle: key_valid=0 and overrun=0 on the next edge.
  - key_ack while key_valid=0 is ignored.
  - key_code is stable whenever key_valid=1.
- Latency: from ROW stable-low at the selected column to key_valid high is at most 2 + CLK_DIV*(DEBOUNCE_TICKS+1) cycles.
- Width rules:
  - cnt is 8 bits and saturates at DEBOUNCE_TICKS.
  - The tick counter is sized by $clog2(CLK_DIV).

Test Plan:
- Reset, no press: CLK_DIV=4, DEBOUNCE_TICKS=3, ROW=4'b1111 -> COL cycles 1110,1101,1011,0111,1110, changing every 4 clocks; key_valid stays 0.
- Clean press: ROW[2]=0 only while COL=4'b1011 (col 2), held 40 clocks -> key_valid rises within 2+4*4=18 clocks of first detection; key_code=4'b1010. key_ack pulse -> key_valid=0 next cycle.
- Bounce rejection: ROW[1] toggles low/high on alternate ticks for 10 ticks at col 0 -> key_valid never asserts; FSM returns to SCAN; column resumes advancing.
- Hold and release: key (row 3, col 1) held 100 ticks -> exactly one accept, key_code=4'b1101, COL frozen at 4'b1101. Release with 1 bounce tick, then clean high -> no second key; scanning resumes only after 3 clean high ticks.
- Overrun: accept key 4'b0000, no ack, then press/release key 4'b0101 -> key_code stays 4'b0000 and overrun=1. key_ack -> key_valid=0, overrun=0. Ack asserted exactly on an accept edge -> new code loaded, overrun stays 0.
- Reset mid-debounce: rst_n low 3 cycles during DEBOUNCE -> all outputs at reset values, COL=4'b1110; no key is emitted after release.

Source files
------------

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: walks active-low columns, debounces press/release on scan ticks,
// and offers the encoded key {row,col} through a valid/ack holding register.
// Press-to-valid latency <= 2 + CLK_DIV*(DEBOUNCE_TICKS+1) clocks; unacked keys set a sticky overrun.
module keypad_scan #(
  parameter int CLK_DIV        = 50000,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] ROW,
  output logic [3:0] COL,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       overrun
);

  localparam int            TW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);
  localparam logic [7:0]    DB_LAST   = 8'(DEBOUNCE_TICKS);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HOLD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_e;

  logic [TW-1:0] div_q, div_d;
  logic          tick;
  logic [3:0]    row_meta_q;
  logic [3:0]    rs_q;

  state_e        state_q, state_d;
  logic [1:0]    col_q, col_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    cnt_inc;
  logic [3:0]    ref_q, ref_d;
  logic          accept;

  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          ovr_q, ovr_d;

  // Lowest-numbered low row wins when several rows are pulled down together.
  function automatic logic [1:0] low_row(input logic [3:0] r);
    if (!r[0])      return 2'd0;
    else if (!r[1]) return 2'd1;
    else if (!r[2]) return 2'd2;
    else            return 2'd3;
  endfunction

  assign tick    = (div_q == TICK_LAST);
  assign div_d   = tick ? '0 : div_q + 1'b1;
  assign cnt_inc = (cnt_q >= DB_LAST) ? DB_LAST : cnt_q + 8'd1;

  // Scan-tick divider and two-flop synchronizer for the asynchronous row pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= '0;
      row_meta_q <= 4'b1111;
      rs_q       <= 4'b1111;
    end else begin
      div_q      <= div_d;
      row_meta_q <= ROW;
      rs_q       <= row_meta_q;
    end
  end

  // FSM state register together with the column, debounce count and reference row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_SCAN;
      col_q   <= 2'd0;
      cnt_q   <= 8'd0;
      ref_q   <= 4'b1111;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      ref_q   <= ref_d;
    end
  end

  // Next-state logic; nothing moves between ticks so each column settles a full tick period.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    ref_d   = ref_q;
    accept  = 1'b0;
    if (tick) begin
      case (state_q)
        ST_SCAN: begin
          if (rs_q == 4'b1111) begin
            col_d = col_q + 2'd1;
          end else begin
            ref_d   = rs_q;
            cnt_d   = 8'd0;
            state_d = ST_DEBOUNCE;
          end
        end
        ST_DEBOUNCE: begin
          if (rs_q == ref_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DB_LAST) begin
              accept  = 1'b1;
              state_d = ST_HOLD;
            end
          end else begin
            // Bounce during press: retry this same column without emitting anything.
            state_d = ST_SCAN;
          end
        end
        ST_HOLD: begin
          // Any non-idle pattern, even another row, keeps us here: no auto-repeat.
          if (rs_q == 4'b1111) begin
            cnt_d   = 8'd0;
            state_d = ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (rs_q == 4'b1111) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DB_LAST) begin
              col_d   = col_q + 2'd1;
              state_d = ST_SCAN;
            end
          end else begin
            state_d = ST_HOLD;
          end
        end
        default: state_d = ST_SCAN;
      endcase
    end
  end

  // Output decode and holding-register update: an ack in the accept cycle frees the slot in time.
  always_comb begin
    COL     = ~(4'b0001 << col_q);
    code_d  = code_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (accept) begin
      if (!valid_q || key_ack) begin
        code_d  = {low_row(ref_q), col_q};
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (key_ack && valid_q) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  // Key holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q  <= 4'd0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      code_q  <= code_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: emulates a 4x4 key matrix, runs directed scenarios then random presses,
// and compares the DUT every cycle against a cycle-level behavioural model of the scanner.
module tb_keypad_scan;

  localparam int CLK_DIV = 4;
  localparam int DB      = 3;

  localparam int MD_SCAN = 0;
  localparam int MD_DEB  = 1;
  localparam int MD_HOLD = 2;
  localparam int MD_REL  = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] ROW;
  logic [3:0] COL;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack;
  logic       overrun;

  logic       key_down;
  logic [1:0] key_row;
  logic [1:0] key_col;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  int         m_cyc;
  logic [3:0] m_sync[$];
  int         m_mode;
  int         m_col;
  int         m_cnt;
  logic [3:0] m_ref;
  logic [3:0] m_code;
  bit         m_valid;
  bit         m_ovr;

  keypad_scan #(.CLK_DIV(CLK_DIV), .DEBOUNCE_TICKS(DB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ROW       (ROW),
    .COL       (COL),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ack   (key_ack),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // A single pressed key shorts its row to its column when that column is driven low.
  assign ROW = (key_down && !COL[key_col]) ? ~(4'b0001 << key_row) : 4'b1111;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic int first_low(input logic [3:0] r);
    for (int i = 0; i < 4; i++)
      if (!r[i]) return i;
    return 3;
  endfunction

  task automatic model_reset();
    m_cyc = 0;
    m_sync.delete();
    m_sync.push_back(4'b1111);
    m_sync.push_back(4'b1111);
    m_mode  = MD_SCAN;
    m_col   = 0;
    m_cnt   = 0;
    m_ref   = 4'b1111;
    m_code  = 4'd0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
  endtask

  function automatic bit model_tick();
    return (m_cyc % CLK_DIV) == (CLK_DIV - 1);
  endfunction

  function automatic bit will_accept();
    return model_tick() && m_mode == MD_DEB && m_sync[0] == m_ref && (m_cnt + 1) == DB;
  endfunction

  // One rising edge of the scanner, described by its rules rather than its registers.
  task automatic model_edge(input logic [3:0] row_now, input bit ack_now);
    bit         tick;
    bit         acc;
    logic [3:0] rs;
    tick = model_tick();
    rs   = m_sync[0];
    acc  = 1'b0;
    m_cyc++;
    m_sync.push_back(row_now);
    void'(m_sync.pop_front());
    if (tick) begin
      case (m_mode)
        MD_SCAN: begin
          if (rs == 4'b1111) m_col = (m_col + 1) % 4;
          else begin m_ref = rs; m_cnt = 0; m_mode = MD_DEB; end
        end
        MD_DEB: begin
          if (rs == m_ref) begin
            m_cnt = (m_cnt < DB) ? m_cnt + 1 : DB;
            if (m_cnt == DB) begin acc = 1'b1; m_mode = MD_HOLD; end
          end else m_mode = MD_SCAN;
        end
        MD_HOLD: begin
          if (rs == 4'b1111) begin m_cnt = 0; m_mode = MD_REL; end
        end
        default: begin
          if (rs == 4'b1111) begin
            m_cnt = (m_cnt < DB) ? m_cnt + 1 : DB;
            if (m_cnt == DB) begin m_col = (m_col + 1) % 4; m_mode = MD_SCAN; end
          end else m_mode = MD_HOLD;
        end
      endcase
    end
    if (acc) begin
      if (!m_valid || ack_now) begin
        m_code  = 4'(first_low(m_ref) * 4 + m_col);
        m_valid = 1'b1;
      end else m_ovr = 1'b1;
    end else if (ack_now && m_valid) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
  endtask

  // Advance one clock: model the coming edge from the current pins, then compare at the falling edge.
  task automatic step();
    logic [3:0] rows;
    logic [3:0] ec;
    rows = (key_down && !COL[key_col]) ? ~(4'b0001 << key_row) : 4'b1111;
    if (!rst_n) model_reset();
    else model_edge(rows, key_ack);
    @(negedge clk);
    ec = 4'b1111 ^ (4'b0001 << m_col);
    chk("cycle", {6'd0, COL, key_code, key_valid, overrun},
                 {6'd0, ec, m_code, m_valid, m_ovr});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic press(input int r, input int c);
    key_row  = 2'(r);
    key_col  = 2'(c);
    key_down = 1'b1;
  endtask

  initial begin
    int  t0;
    int  lat;
    bit  hit;
    rst_n    = 1'b0;
    key_down = 1'b0;
    key_row  = 2'd0;
    key_col  = 2'd0;
    key_ack  = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_col",   16'(COL),       16'h000e);
    chk("rst_code",  16'(key_code),  16'h0000);
    chk("rst_valid", 16'(key_valid), 16'h0000);
    chk("rst_ovr",   16'(overrun),   16'h0000);

    // Idle scanning: column advances once per tick.
    rst_n = 1'b1;
    run(4);
    chk("idle_col1", 16'(COL), 16'h000d);
    run(12);
    chk("idle_wrap", 16'(COL), 16'h000e);
    chk("idle_valid", 16'(key_valid), 16'h0000);

    // Clean press at row 2, column 2, with latency measured from the column going low.
    press(2, 2);
    t0  = -1;
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (COL == 4'b1011 && t0 < 0) t0 = i;
      if (key_valid && t0 >= 0 && lat < 0) lat = i - t0;
    end
    chk("clean_valid", 16'(key_valid), 16'h0001);
    chk("clean_code",  16'(key_code),  16'h000a);
    chk("clean_latency_ok", 16'(lat >= 0 && lat <= 2 + CLK_DIV * (DB + 1)), 16'h0001);
    key_ack = 1'b1;
    step();
    key_ack = 1'b0;
    chk("clean_ack", 16'(key_valid), 16'h0000);
    key_down = 1'b0;
    run(30);

    // Bounce: row 1 at column 0 alternates every tick; never a stable run long enough.
    key_row = 2'd1;
    key_col = 2'd0;
    for (int t = 0; t < 10; t++) begin
      key_down = (t % 2 == 0);
      run(CLK_DIV);
    end
    key_down = 1'b0;
    run(20);
    chk("bounce_valid", 16'(key_valid), 16'h0000);

    // Long hold: one key only, column frozen, then a bouncy release.
    press(3, 1);
    run(400);
    chk("hold_code",  16'(key_code),  16'h000d);
    chk("hold_valid", 16'(key_valid), 16'h0001);
    chk("hold_col",   16'(COL),       16'h000d);
    key_ack = 1'b1;
    step();
    key_ack = 1'b0;
    run(40);
    chk("hold_no_repeat", 16'(key_valid), 16'h0000);
    key_down = 1'b0;
    run(4);
    chk("rel_frozen", 16'(COL), 16'h000d);
    key_down = 1'b1;
    run(4);
    key_down = 1'b0;
    run(40);
    chk("rel_no_second", 16'(key_valid), 16'h0000);

    // Overrun: second key arrives while the first is still pending.
    press(0, 0);
    run(60);
    key_down = 1'b0;
    run(40);
    press(1, 1);
    run(60);
    key_down = 1'b0;
    run(40);
    chk("ovr_code",  16'(key_code),  16'h0000);
    chk("ovr_valid", 16'(key_valid), 16'h0001);
    chk("ovr_flag",  16'(overrun),   16'h0001);
    key_ack = 1'b1;
    step();
    key_ack = 1'b0;
    chk("ovr_ack_valid", 16'(key_valid), 16'h0000);
    chk("ovr_ack_flag",  16'(overrun),   16'h0000);

    // Ack landing exactly on the accept edge replaces the pending key without overrun.
    press(2, 0);
    run(60);
    key_down = 1'b0;
    run(40);
    press(3, 3);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      key_ack = will_accept();
      hit     = key_ack;
      step();
    end
    key_ack = 1'b0;
    chk("ackedge_seen",  16'(hit),       16'h0001);
    chk("ackedge_code",  16'(key_code),  16'h000f);
    chk("ackedge_valid", 16'(key_valid), 16'h0001);
    chk("ackedge_ovr",   16'(overrun),   16'h0000);
    key_down = 1'b0;
    run(40);
    key_ack = 1'b1;
    step();
    key_ack = 1'b0;

    // Reset in the middle of debouncing discards the press.
    press(0, 2);
    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      step();
      hit = (m_mode == MD_DEB);
    end
    chk("rstdeb_reached", 16'(hit), 16'h0001);
    rst_n = 1'b0;
    run(3);
    chk("rstdeb_col",   16'(COL),       16'h000e);
    chk("rstdeb_valid", 16'(key_valid), 16'h0000);
    chk("rstdeb_code",  16'(key_code),  16'h0000);
    key_down = 1'b0;
    rst_n    = 1'b1;
    run(40);
    chk("rstdeb_no_key", 16'(key_valid), 16'h0000);

    // Random presses, bounces, acks and occasional resets.
    for (int it = 0; it < 150; it++) begin
      press($urandom_range(0, 3), $urandom_range(0, 3));
      for (int i = 0, n = $urandom_range(5, 120); i < n; i++) begin
        key_ack = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 31) == 0) key_down = ~key_down;
        step();
      end
      key_down = 1'b0;
      for (int i = 0, n = $urandom_range(5, 80); i < n; i++) begin
        key_ack = ($urandom_range(0, 7) == 0);
        step();
      end
      key_ack = 1'b0;
      if ($urandom_range(0, 19) == 0) begin
        rst_n = 1'b0;
        run($urandom_range(1, 3));
        rst_n = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
